dram_mbank_cmd_fsm: RTL and testbench
=====================================

Name: dram_mbank_cmd_fsm

Overview:
- Parametrised successor to the single-bank DRAM command FSM.
- Tracks an open row per bank (open-page policy) and classifies each request as row hit, row miss or bank closed.
- Sequences PRECHARGE/ACTIVATE/READ/WRITE/REFRESH with internal per-state timing counters, replacing the separate timing-done inputs.
- Sits between the request arbiter and the DRAM command/address driver.

Parameters:
- NUM_BANKS, 4: bank count; power of two, ≥2.
- ROW_W, 15: row address width.
- T_RCD, 3: ACTIVATE state length in cycles (≥1).
- T_RP, 3: PRECHARGE state length in cycles (≥1).
- T_RD, 4: READ state length in cycles (≥1).
- T_WR, 4: WRITE state length in cycles (≥1).
- T_RFC, 16: REFRESH state length in cycles (≥1).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- init_done  in  1  DRAM power-up init complete
- init_req  out  1  request init sequence
- req_valid  in  1  access request valid
- req_wen  in  1  1=write, 0=read
- req_bank  in  $clog2(NUM_BANKS)  target bank
- req_row  in  ROW_W  target row
- req_ready  out  1  request accepted this cycle
- rf_req  in  1  refresh due (level)
- rf_ack  out  1  one-cycle pulse when REFRESH completes
- cmd_state  out  dram_state_t  current state
- ncmd_state  out  dram_state_t  next state (combinational)
- cmd_bank  out  $clog2(NUM_BANKS)  bank of current command
- cmd_row  out  ROW_W  row of current command
- row_hit  out  1  latched request was a hit
- ram_wait  out  1  high while a request is held and not yet in READ/WRITE
- done  out  1  one-cycle pulse on last cycle of READ/WRITE

Behaviour:
- Reset values:
  - cmd_state=POWER_UP; all open_valid=0.
  - init_req=1 (Moore output of POWER_UP).
  - req_ready, rf_ack, row_hit, ram_wait, done, cmd_bank, cmd_row = 0.
- Reset mid-operation discards the held request and all bank state.
- States: POWER_UP, IDLE, ACTIVATE, READ, WRITE, PRECHARGE, PRE_ALL, REFRESH.
- POWER_UP: init_req=1; goes to IDLE the cycle after init_done=1.
- IDLE arbitration:
  - rf_req has priority over req_valid.
  - rf_req: PRE_ALL if any bank open, else REFRESH.
  - Else req_valid: req_ready=1 combinationally, request latched (wen/bank/row) and classified against the bank table.
    - hit (open_valid[bank] && open_row[bank]==row): READ/WRITE directly, row_hit=1.
    - miss (open with another row): PRECHARGE.
    - closed bank: ACTIVATE.
- req_ready is only ever high in IDLE with rf_req=0.
- Timed states:
  - Counter is loaded with T-1 on entry and decrements each cycle.
  - Exit on the cycle the counter reads 0, so each state lasts exactly T cycles.
  - ncmd_state reflects the exit combinationally on that cycle.
- Exits and table updates:
  - PRECHARGE: exit to ACTIVATE; clears open_valid[cmd_bank].
  - PRE_ALL (lasts T_RP): exit to REFRESH; clears all open_valid.
  - ACTIVATE: exit to READ/WRITE; sets open_valid[cmd_bank]=1 and open_row[cmd_bank]=cmd_row.
  - READ/WRITE: last cycle pulses done; exit to IDLE.
  - REFRESH: exit to IDLE; pulses rf_ack on its last cycle.
- rf_req asserted mid-access is not serviced until the access returns to IDLE.
- Request hold: ram_wait=1 from acceptance until entering READ/WRITE.
- Request is held internally; req_* may change after req_ready.
- Banks not addressed keep their open rows across accesses.
- Bank table is flops only, no memory macro.

Optional Feature:
- Macro: DRAM_CLOSED_PAGE_EN.
- Defined:
  - After READ/WRITE the FSM enters PRECHARGE for cmd_bank (T_RP), then IDLE.
  - Every request therefore classifies as closed; row_hit is always 0.
  - rf_req goes straight to REFRESH.
- Undefined: open-page behaviour as above.

Decomposition:
- dram_pkg gains:
  - dram_state_t entries PRE_ALL and POWER_UP, if absent.
  - typedef row_class_t {ROW_HIT, ROW_MISS, ROW_CLOSED}.
  - Default timing constants.
- One natural sub-module, dram_bank_table: open_row/open_valid storage, hit/miss lookup, set/clear/clear-all ports.
- Interface command_fsm_if gains a parametrised variant carrying the new ports.

Test Plan:
- Power-up and first read: RST, then init_done=1 → IDLE. Read bank0 row 0x12 → ACTIVATE 3 cycles, READ 4 cycles, done on the 7th cycle after accept.
- Open-page hit: read bank0 row 0x12 again → row_hit=1, READ entered the cycle after accept, done after 4 cycles.
- Row miss: write bank0 row 0x34 → PRECHARGE 3, ACTIVATE 3, WRITE 4; table then holds row 0x34 for bank0.
- Bank independence: open bank1 row 0x5, then bank2 row 0x7, then bank1 row 0x5 → third access is a hit.
- Refresh with simultaneous request: rf_req=1 and req_valid=1 in IDLE with banks open → req_ready=0, PRE_ALL 3, REFRESH 16, rf_ack pulse. The following request classifies as closed.
- Reset mid-ACTIVATE: RST for one cycle → POWER_UP, init_req=1. Later access to the same bank performs ACTIVATE (not a hit).

Source files
------------

// File: rtl/dram_mbank_cmd_fsm_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dram_mbank_cmd_fsm_pkg
// Brief    : Shared types and default timing for the multi-bank DRAM
//            command FSM and its bank table.
// Revision : 1.0 - initial multi-bank release
// ============================================================================
package dram_mbank_cmd_fsm_pkg;

  // Command FSM states; 3-bit encoding covers all eight states
  typedef enum logic [2:0] {
    POWER_UP  = 3'd0,
    IDLE      = 3'd1,
    ACTIVATE  = 3'd2,
    READ      = 3'd3,
    WRITE     = 3'd4,
    PRECHARGE = 3'd5,
    PRE_ALL   = 3'd6,
    REFRESH   = 3'd7
  } dram_state_t;

  // Classification of an incoming request against the open-row table
  typedef enum logic [1:0] {
    ROW_HIT    = 2'd0,
    ROW_MISS   = 2'd1,
    ROW_CLOSED = 2'd2
  } row_class_t;

  // Default geometry and timing (state lengths in clock cycles)
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_ROW_W     = 15;
  localparam int DEF_T_RCD     = 3;
  localparam int DEF_T_RP      = 3;
  localparam int DEF_T_RD      = 4;
  localparam int DEF_T_WR      = 4;
  localparam int DEF_T_RFC     = 16;

  // Larger of two integers, used to size the shared timing counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : dram_mbank_cmd_fsm_pkg
`default_nettype wire

// File: rtl/dram_mbank_cmd_fsm_bank_table.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dram_mbank_cmd_fsm_bank_table
// Brief    : Per-bank open-row storage (flops only) with hit/miss/closed
//            lookup, single-bank set/clear and clear-all.
// Revision : 1.0 - initial multi-bank release
// ============================================================================
module dram_mbank_cmd_fsm_bank_table
  import dram_mbank_cmd_fsm_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ROW_W     = DEF_ROW_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [$clog2(NUM_BANKS)-1:0] lookup_bank,
  input  logic [ROW_W-1:0]             lookup_row,
  output row_class_t                   lookup_class,
  output logic                         any_open,
  input  logic                         set_en,
  input  logic [$clog2(NUM_BANKS)-1:0] set_bank,
  input  logic [ROW_W-1:0]             set_row,
  input  logic                         clr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] clr_bank,
  input  logic                         clr_all
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  logic [NUM_BANKS-1:0] open_valid;
  logic [ROW_W-1:0]     open_row [NUM_BANKS];

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic             valid_q;
      logic [ROW_W-1:0] row_q;

      // One bank entry: clear wins over set so PRE_ALL can never leave a bank open
      always_ff @(posedge CLK) begin
        if (RST) begin
          valid_q <= 1'b0;
          row_q   <= '0;
        end else if (clr_all || (clr_en && (clr_bank == BANK_W'(b)))) begin
          valid_q <= 1'b0;
        end else if (set_en && (set_bank == BANK_W'(b))) begin
          valid_q <= 1'b1;
          row_q   <= set_row;
        end
      end

      assign open_valid[b] = valid_q;
      assign open_row[b]   = row_q;
    end
  endgenerate

  // Classify the looked-up bank/row against the stored open row
  always_comb begin
    lookup_class = ROW_CLOSED;
    if (open_valid[lookup_bank]) begin
      lookup_class = (open_row[lookup_bank] == lookup_row) ? ROW_HIT : ROW_MISS;
    end
    any_open = |open_valid;
  end

endmodule : dram_mbank_cmd_fsm_bank_table
`default_nettype wire

// File: rtl/dram_mbank_cmd_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dram_mbank_cmd_fsm
// Brief    : Multi-bank DRAM command sequencer. Tracks an open row per bank,
//            classifies requests as hit/miss/closed and sequences
//            PRECHARGE/ACTIVATE/READ/WRITE/REFRESH with internal timers.
//            Build option DRAM_CLOSED_PAGE_EN: precharge the bank after every
//            access (closed-page policy); refresh then never needs PRE_ALL.
// Revision : 1.0 - initial multi-bank release
// ============================================================================
module dram_mbank_cmd_fsm
  import dram_mbank_cmd_fsm_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RD      = DEF_T_RD,
  parameter int T_WR      = DEF_T_WR,
  parameter int T_RFC     = DEF_T_RFC
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         init_done,
  output logic                         init_req,
  input  logic                         req_valid,
  input  logic                         req_wen,
  input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
  input  logic [ROW_W-1:0]             req_row,
  output logic                         req_ready,
  input  logic                         rf_req,
  output logic                         rf_ack,
  output dram_state_t                  cmd_state,
  output dram_state_t                  ncmd_state,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [ROW_W-1:0]             cmd_row,
  output logic                         row_hit,
  output logic                         ram_wait,
  output logic                         done
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int T_MAX  = max_int(max_int(max_int(T_RCD, T_RP), max_int(T_RD, T_WR)), T_RFC);
  localparam int CNT_W  = $clog2(T_MAX + 1);

  dram_state_t        state_q;
  dram_state_t        state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_zero;
  logic               accept;
  logic               wen_q;
  logic [BANK_W-1:0]  bank_q;
  logic [ROW_W-1:0]   row_q;
  logic               hit_q;
  logic               held_q;
  row_class_t         tbl_class;
  row_class_t         req_class;
  logic               tbl_any_open;
  dram_state_t        data_state;

  // Timer preload for a state: length minus one, so the state lasts exactly T cycles
  function automatic logic [CNT_W-1:0] load_val(input dram_state_t s);
    case (s)
      ACTIVATE:           load_val = CNT_W'(T_RCD - 1);
      PRECHARGE, PRE_ALL: load_val = CNT_W'(T_RP - 1);
      READ:               load_val = CNT_W'(T_RD - 1);
      WRITE:              load_val = CNT_W'(T_WR - 1);
      REFRESH:            load_val = CNT_W'(T_RFC - 1);
      default:            load_val = '0;
    endcase
  endfunction

  dram_mbank_cmd_fsm_bank_table #(
    .NUM_BANKS (NUM_BANKS),
    .ROW_W     (ROW_W)
  ) u_bank_table (
    .CLK          (CLK),
    .RST          (RST),
    .lookup_bank  (req_bank),
    .lookup_row   (req_row),
    .lookup_class (tbl_class),
    .any_open     (tbl_any_open),
    .set_en       ((state_q == ACTIVATE) && cnt_zero),
    .set_bank     (bank_q),
    .set_row      (row_q),
    .clr_en       ((state_q == PRECHARGE) && cnt_zero),
    .clr_bank     (bank_q),
    .clr_all      ((state_q == PRE_ALL) && cnt_zero)
  );

  assign cnt_zero   = (cnt_q == '0);
  assign accept     = (state_q == IDLE) && !rf_req && req_valid;
  assign data_state = wen_q ? WRITE : READ;

`ifdef DRAM_CLOSED_PAGE_EN
  // Every bank is precharged after use, so nothing is ever open at arbitration
  logic unused_tbl;
  assign unused_tbl = ^{tbl_class, tbl_any_open};
  assign req_class  = ROW_CLOSED;
`else
  assign req_class  = tbl_class;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= POWER_UP;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-state timer: preload on every state change, count down to zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= load_val(state_d);
    end else if (!cnt_zero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      POWER_UP: begin
        if (init_done) state_d = IDLE;
      end
      IDLE: begin
        if (rf_req) begin
`ifdef DRAM_CLOSED_PAGE_EN
          state_d = REFRESH;
`else
          state_d = tbl_any_open ? PRE_ALL : REFRESH;
`endif
        end else if (req_valid) begin
          case (req_class)
            ROW_HIT:  state_d = req_wen ? WRITE : READ;
            ROW_MISS: state_d = PRECHARGE;
            default:  state_d = ACTIVATE;
          endcase
        end
      end
      ACTIVATE: begin
        if (cnt_zero) state_d = data_state;
      end
      READ, WRITE: begin
`ifdef DRAM_CLOSED_PAGE_EN
        if (cnt_zero) state_d = PRECHARGE;
`else
        if (cnt_zero) state_d = IDLE;
`endif
      end
      PRECHARGE: begin
`ifdef DRAM_CLOSED_PAGE_EN
        if (cnt_zero) state_d = IDLE;
`else
        if (cnt_zero) state_d = ACTIVATE;
`endif
      end
      PRE_ALL: begin
        if (cnt_zero) state_d = REFRESH;
      end
      REFRESH: begin
        if (cnt_zero) state_d = IDLE;
      end
      default: state_d = POWER_UP;
    endcase
  end

  // Request holding register: captured on acceptance so req_* may move on
  always_ff @(posedge CLK) begin
    if (RST) begin
      wen_q  <= 1'b0;
      bank_q <= '0;
      row_q  <= '0;
      hit_q  <= 1'b0;
      held_q <= 1'b0;
    end else if (accept) begin
      wen_q  <= req_wen;
      bank_q <= req_bank;
      row_q  <= req_row;
      hit_q  <= (req_class == ROW_HIT);
      held_q <= !((state_d == READ) || (state_d == WRITE));
    end else if ((state_d == READ) || (state_d == WRITE)) begin
      held_q <= 1'b0;
    end
  end

  // Output decode
  always_comb begin
    cmd_state  = state_q;
    ncmd_state = state_d;
    init_req   = (state_q == POWER_UP);
    req_ready  = accept;
    done       = ((state_q == READ) || (state_q == WRITE)) && cnt_zero;
    rf_ack     = (state_q == REFRESH) && cnt_zero;
    ram_wait   = held_q;
    row_hit    = hit_q;
    cmd_bank   = bank_q;
    cmd_row    = row_q;
  end

endmodule : dram_mbank_cmd_fsm
`default_nettype wire

// File: tb/tb_dram_mbank_cmd_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dram_mbank_cmd_fsm
// Brief    : Directed self-checking bench for dram_mbank_cmd_fsm (default
//            open-page build) with hand-computed state sequences.
// Revision : 1.0 - initial multi-bank release
// ============================================================================
module tb_dram_mbank_cmd_fsm;
  import dram_mbank_cmd_fsm_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        init_done;
  logic        init_req;
  logic        req_valid;
  logic        req_wen;
  logic [1:0]  req_bank;
  logic [14:0] req_row;
  logic        req_ready;
  logic        rf_req;
  logic        rf_ack;
  dram_state_t cmd_state;
  dram_state_t ncmd_state;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic        row_hit;
  logic        ram_wait;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  dram_mbank_cmd_fsm dut (
    .CLK        (CLK),
    .RST        (RST),
    .init_done  (init_done),
    .init_req   (init_req),
    .req_valid  (req_valid),
    .req_wen    (req_wen),
    .req_bank   (req_bank),
    .req_row    (req_row),
    .req_ready  (req_ready),
    .rf_req     (rf_req),
    .rf_ack     (rf_ack),
    .cmd_state  (cmd_state),
    .ncmd_state (ncmd_state),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .row_hit    (row_hit),
    .ram_wait   (ram_wait),
    .done       (done)
  );

  // Free-running clock, 10 ns period
  always #5 CLK = ~CLK;

  // Run-away guard
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One access from IDLE: expected PRECHARGE/ACTIVATE cycle counts and hit flag
  task automatic do_access(input string tag, input logic wen, input logic [1:0] bank,
                           input logic [14:0] row, input int n_pre, input int n_act,
                           input logic exp_hit);
    dram_state_t data_st;
    dram_state_t first_st;
    data_st  = wen ? WRITE : READ;
    first_st = (n_pre > 0) ? PRECHARGE : ((n_act > 0) ? ACTIVATE : data_st);
    req_valid = 1'b1;
    req_wen   = wen;
    req_bank  = bank;
    req_row   = row;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " ncmd_state"}, 32'(ncmd_state), 32'(first_st));
    step();
    // Scramble the request lines to prove the request is held internally
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_bank  = ~bank;
    req_row   = ~row;
    check({tag, " row_hit"}, 32'(row_hit), 32'(exp_hit));
    check({tag, " cmd_bank"}, 32'(cmd_bank), 32'(bank));
    check({tag, " cmd_row"}, 32'(cmd_row), 32'(row));
    for (int i = 0; i < n_pre; i++) begin
      check({tag, " pre state"}, 32'(cmd_state), 32'(PRECHARGE));
      check({tag, " pre ram_wait"}, 32'(ram_wait), 32'd1);
      step();
    end
    for (int i = 0; i < n_act; i++) begin
      check({tag, " act state"}, 32'(cmd_state), 32'(ACTIVATE));
      check({tag, " act ram_wait"}, 32'(ram_wait), 32'd1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check({tag, " data state"}, 32'(cmd_state), 32'(data_st));
      check({tag, " data ram_wait"}, 32'(ram_wait), 32'd0);
      check({tag, " done"}, 32'(done), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    check({tag, " back idle"}, 32'(cmd_state), 32'(IDLE));
    check({tag, " done low"}, 32'(done), 32'd0);
  endtask

  initial begin
    RST       = 1'b1;
    init_done = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_bank  = 2'd0;
    req_row   = 15'd0;
    rf_req    = 1'b0;
    step();
    step();

    // Reset values
    check("rst state", 32'(cmd_state), 32'(POWER_UP));
    check("rst init_req", 32'(init_req), 32'd1);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rf_ack", 32'(rf_ack), 32'd0);
    check("rst row_hit", 32'(row_hit), 32'd0);
    check("rst ram_wait", 32'(ram_wait), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst cmd_bank", 32'(cmd_bank), 32'd0);
    check("rst cmd_row", 32'(cmd_row), 32'd0);

    // Stay in POWER_UP until init_done
    RST = 1'b0;
    step();
    check("pu wait", 32'(cmd_state), 32'(POWER_UP));
    init_done = 1'b1;
    #1;
    check("pu ncmd", 32'(ncmd_state), 32'(IDLE));
    step();
    check("pu to idle", 32'(cmd_state), 32'(IDLE));
    check("idle init_req", 32'(init_req), 32'd0);
    check("idle no req", 32'(req_ready), 32'd0);

    // First read: closed bank -> ACTIVATE 3 + READ 4
    do_access("rd0", 1'b0, 2'd0, 15'h12, 0, 3, 1'b0);
    // Same row again: hit -> READ directly
    do_access("hit0", 1'b0, 2'd0, 15'h12, 0, 0, 1'b1);
    // Different row on bank0: PRECHARGE 3 + ACTIVATE 3 + WRITE 4
    do_access("miss0", 1'b1, 2'd0, 15'h34, 3, 3, 1'b0);
    // Table now holds 0x34 for bank0
    do_access("hit34", 1'b0, 2'd0, 15'h34, 0, 0, 1'b1);
    // Bank independence
    do_access("b1", 1'b0, 2'd1, 15'h5, 0, 3, 1'b0);
    do_access("b2", 1'b1, 2'd2, 15'h7, 0, 3, 1'b0);
    do_access("b1hit", 1'b0, 2'd1, 15'h5, 0, 0, 1'b1);

    // Refresh wins over a simultaneous request; banks open -> PRE_ALL first
    rf_req    = 1'b1;
    req_valid = 1'b1;
    req_bank  = 2'd0;
    req_row   = 15'h34;
    #1;
    check("rf req_ready", 32'(req_ready), 32'd0);
    check("rf ncmd", 32'(ncmd_state), 32'(PRE_ALL));
    step();
    rf_req    = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rf pre_all", 32'(cmd_state), 32'(PRE_ALL));
      check("rf pre_all ack", 32'(rf_ack), 32'd0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      check("rf refresh", 32'(cmd_state), 32'(REFRESH));
      check("rf ack", 32'(rf_ack), (i == 15) ? 32'd1 : 32'd0);
      step();
    end
    check("rf idle", 32'(cmd_state), 32'(IDLE));
    check("rf ack low", 32'(rf_ack), 32'd0);
    // Previously open bank1 row 5 is now closed
    do_access("post_rf", 1'b0, 2'd1, 15'h5, 0, 3, 1'b0);

    // Reset in the middle of ACTIVATE
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_bank  = 2'd2;
    req_row   = 15'h7;
    #1;
    check("mid ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("mid act", 32'(cmd_state), 32'(ACTIVATE));
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid rst state", 32'(cmd_state), 32'(POWER_UP));
    check("mid rst init_req", 32'(init_req), 32'd1);
    check("mid rst ram_wait", 32'(ram_wait), 32'd0);
    check("mid rst cmd_bank", 32'(cmd_bank), 32'd0);
    check("mid rst cmd_row", 32'(cmd_row), 32'd0);
    step();
    check("mid rst idle", 32'(cmd_state), 32'(IDLE));
    // Bank1 row 5 was open before reset; table must have been wiped
    do_access("after_rst", 1'b0, 2'd1, 15'h5, 0, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dram_mbank_cmd_fsm
`default_nettype wire
